// File: rtl/mem_pkg.sv
// Shared state encoding and latency limit for the data-memory responder.
package mem_pkg;

  localparam int unsigned MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Used as an elaboration-time guard by the responder.
  function automatic bit latency_legal(input int unsigned lat);
    return lat <= MAX_LATENCY;
  endfunction

endpackage

// File: rtl/be_ram.sv
// Word array with byte-enable synchronous write and asynchronous read.
module be_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states in front of be_ram.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  if (!latency_legal(LATENCY)) begin : gen_latency_check
    $error("LATENCY exceeds MAX_LATENCY");
  end

  localparam logic [3:0] LatLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, addr_err, ram_we;
  logic [31:0] ram_rdata;

  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Traffic presented while in reset must not reach the array.
  assign accept = req_valid && req_ready && !rst;
  assign ram_we = accept && req_write && !addr_err;

  be_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (req_addr[ADDR_WIDTH+1:2]),
    .wdata(req_wdata),
    .be   (req_be),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = (req_write || addr_err) ? 32'h0 : ram_rdata;
          err_d   = addr_err;
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
